// File: rtl/spi_mosi_rx_if.sv
// Receive-side bus for spi_mosi_rx: serial input, FIFO drain strobe and
// status outputs. The master drives the serial line and the read/clear
// strobes. The slave is the receiver.
interface spi_mosi_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
);
  logic                  spi_cs;
  logic                  spi_mosi_serial;
  logic                  rd_en;
  logic                  ovr_clr;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  fifo_full;
  logic [ADDR_WIDTH:0]   fifo_count;
  logic                  overrun;
  logic                  frame_err;

  modport master (
    output spi_cs, spi_mosi_serial, rd_en, ovr_clr,
    input  rx_data, rx_valid, fifo_full, fifo_count, overrun, frame_err
  );

  modport slave (
    input  spi_cs, spi_mosi_serial, rd_en, ovr_clr,
    output rx_data, rx_valid, fifo_full, fifo_count, overrun, frame_err
  );
endinterface

// File: rtl/spi_mosi_rx.sv
// SPI MOSI receiver. Shifts serial bits MSB-first into bytes while spi_cs is
// low. Completed bytes go into a small first-word-fall-through FIFO.
// Overruns are flagged with a sticky bit. A frame that ends mid-byte is
// flagged with a one-cycle frame_err pulse.
module spi_mosi_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic         spi_clk,
  input  logic         n_reset,
  spi_mosi_rx_if.slave bus
);

  // bit_cnt spans 0..DATA_WIDTH-1. It wraps to 0 on the completing bit.
  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                               state_q, state_d;
  logic [CNT_W-1:0]                     bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]                shift_q, shift_d;
  logic                                 frame_err_q, frame_err_d;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
  logic [ADDR_WIDTH-1:0]                wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]                rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]                  count_q, count_d;
  logic                                 overrun_q, overrun_d;

  logic                  byte_done;
  logic [DATA_WIDTH-1:0] byte_val;
  logic                  full, pop, push;

  // Receiver FSM: shift in bits, detect byte completion and partial frames.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    byte_done   = 1'b0;
    byte_val    = {shift_q[DATA_WIDTH-2:0], bus.spi_mosi_serial};
    if (bus.spi_cs) begin
      // Frame closed. Any partial byte is discarded.
      if (state_q == SHIFT && bit_cnt_q != '0) frame_err_d = 1'b1;
      bit_cnt_d = '0;
      shift_d   = '0;
      state_d   = IDLE;
    end else begin
      // IDLE has bit_cnt=0, so its first sample is the MSB, same as SHIFT.
      shift_d = byte_val;
      state_d = SHIFT;
      if (bit_cnt_q == LAST_BIT) begin
        byte_done = 1'b1;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  // FIFO bookkeeping. A pop frees a slot on the same edge, so a push to a
  // full FIFO with a concurrent pop is not an overrun.
  always_comb begin
    full      = (count_q == DEPTH_C);
    pop       = bus.rd_en && (count_q != '0);
    push      = byte_done && (!full || pop);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (push) begin
      mem_d[wr_ptr_q] = byte_val;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // The set is evaluated after the clear, so a new overrun wins over ovr_clr.
    if (bus.ovr_clr) overrun_d = 1'b0;
    if (byte_done && full && !pop) overrun_d = 1'b1;
  end

  // All state registers, cleared asynchronously (FIFO contents included).
  always_ff @(posedge spi_clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
    end
  end

  // Outputs come straight from registers. rx_data is stale when empty.
  assign bus.rx_data    = mem_q[rd_ptr_q];
  assign bus.rx_valid   = (count_q != '0);
  assign bus.fifo_full  = (count_q == DEPTH_C);
  assign bus.fifo_count = count_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_mosi_rx.sv
// Bench for spi_mosi_rx.
// Driven bytes that should land in the FIFO go to a scoreboard queue.
// Each pop compares rx_data against the queue head.
module tb_spi_mosi_rx;
  logic spi_clk = 1'b0;
  logic n_reset;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] sb_q[$];

  spi_mosi_rx_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus ();

  spi_mosi_rx #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .ADDR_WIDTH(2)) dut (
    .spi_clk (spi_clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 spi_clk = ~spi_clk;

  typedef struct {
    logic [7:0] data;
    bit         keep;
    logic [2:0] exp_cnt;
    logic       exp_full;
    logic       exp_ovr;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge spi_clk);
    #1;
  endtask

  // Send the top n bits of b, MSB first. Options assert rd_en/ovr_clr on the
  // last bit. keep marks a byte that the FIFO is expected to accept.
  task automatic send_bits(input logic [7:0] b, input int n, input bit rd_last,
                           input bit clr_last, input bit keep);
    for (int i = 0; i < n; i++) begin
      bus.spi_cs          = 1'b0;
      bus.spi_mosi_serial = b[7-i];
      if (i == n - 1 && rd_last) begin
        if (sb_q.size() == 0) chk("sb_underflow_rd", 1, 0);
        else chk("rd_head", bus.rx_data, sb_q.pop_front());
        bus.rd_en = 1'b1;
      end
      if (i == n - 1 && clr_last) bus.ovr_clr = 1'b1;
      step();
      bus.rd_en   = 1'b0;
      bus.ovr_clr = 1'b0;
    end
    if (keep) sb_q.push_back(b);
  endtask

  // Pop one byte with spi_cs high, checking it against the scoreboard.
  task automatic pop_chk(input string nm);
    bus.spi_cs = 1'b1;
    chk({nm, "_valid"}, bus.rx_valid, 1);
    if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
    else chk(nm, bus.rx_data, sb_q.pop_front());
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    tbl[0] = '{8'h01, 1'b1, 3'd1, 1'b0, 1'b0};
    tbl[1] = '{8'h02, 1'b1, 3'd2, 1'b0, 1'b0};
    tbl[2] = '{8'h03, 1'b1, 3'd3, 1'b0, 1'b0};
    tbl[3] = '{8'h04, 1'b1, 3'd4, 1'b1, 1'b0};
    tbl[4] = '{8'h05, 1'b0, 3'd4, 1'b1, 1'b1};

    n_reset = 1'b0;
    bus.spi_cs = 1'b1;
    bus.spi_mosi_serial = 1'b0;
    bus.rd_en = 1'b0;
    bus.ovr_clr = 1'b0;
    step();
    step();
    n_reset = 1'b1;

    // Idle frame after reset: nothing should move.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_frame_err", bus.frame_err, 0);
    end
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_full", bus.fifo_full, 0);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_overrun", bus.overrun, 0);

    // Single byte 0x01. rx_valid must rise exactly after the 8th edge.
    for (int i = 7; i >= 0; i--) begin
      bus.spi_cs = 1'b0;
      bus.spi_mosi_serial = (i == 0);
      step();
      chk("lat_valid", bus.rx_valid, (i == 0));
    end
    sb_q.push_back(8'h01);
    chk("b01_data", bus.rx_data, 8'h01);
    chk("b01_count", bus.fifo_count, 1);
    pop_chk("b01_pop");
    chk("b01_empty", bus.rx_valid, 0);
    chk("b01_no_ferr", bus.frame_err, 0);

    // Two back-to-back bytes with no idle gap.
    send_bits(8'h47, 8, 0, 0, 1);
    send_bits(8'h61, 8, 0, 0, 1);
    bus.spi_cs = 1'b1;
    step();
    chk("b2b_count", bus.fifo_count, 2);
    chk("b2b_no_ferr", bus.frame_err, 0);
    pop_chk("b2b_pop0");
    pop_chk("b2b_pop1");

    // Table: fill to full, then one byte too many.
    for (int r = 0; r < 5; r++) begin
      send_bits(tbl[r].data, 8, 0, 0, tbl[r].keep);
      chk("tbl_count", bus.fifo_count, 32'(tbl[r].exp_cnt));
      chk("tbl_full", bus.fifo_full, tbl[r].exp_full);
      chk("tbl_ovr", bus.overrun, tbl[r].exp_ovr);
    end
    for (int r = 0; r < 4; r++) pop_chk("tbl_pop");
    chk("tbl_ovr_sticky", bus.overrun, 1);
    bus.ovr_clr = 1'b1;
    step();
    bus.ovr_clr = 1'b0;
    chk("tbl_ovr_clr", bus.overrun, 0);

    // Full FIFO: a set of overrun beats a simultaneous clear.
    send_bits(8'h10, 8, 0, 0, 1);
    send_bits(8'h11, 8, 0, 0, 1);
    send_bits(8'h12, 8, 0, 0, 1);
    send_bits(8'h13, 8, 0, 0, 1);
    send_bits(8'hEE, 8, 0, 1, 0);
    chk("setwin_ovr", bus.overrun, 1);
    bus.spi_cs = 1'b1;
    bus.ovr_clr = 1'b1;
    step();
    bus.ovr_clr = 1'b0;
    chk("setwin_clr", bus.overrun, 0);
    // Full FIFO with a pop on the completion edge: no overrun.
    send_bits(8'h23, 8, 1, 0, 1);
    chk("fullpop_ovr", bus.overrun, 0);
    chk("fullpop_count", bus.fifo_count, 4);
    chk("fullpop_full", bus.fifo_full, 1);
    for (int r = 0; r < 4; r++) pop_chk("fullpop_drain");
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    chk("empty_pop_count", bus.fifo_count, 0);
    chk("empty_pop_valid", bus.rx_valid, 0);

    // Partial frame of 3 bits, then a clean byte.
    send_bits(8'hA0, 3, 0, 0, 0);
    bus.spi_cs = 1'b1;
    step();
    chk("ferr_pulse", bus.frame_err, 1);
    chk("ferr_no_push", bus.fifo_count, 0);
    step();
    chk("ferr_one_cycle", bus.frame_err, 0);
    send_bits(8'h0A, 8, 0, 0, 1);
    bus.spi_cs = 1'b1;
    step();
    chk("ferr_next_count", bus.fifo_count, 1);
    chk("ferr_next_noerr", bus.frame_err, 0);
    pop_chk("ferr_next_pop");

    // Asynchronous reset mid-byte with a byte already queued.
    send_bits(8'h55, 8, 0, 0, 1);
    send_bits(8'hFF, 5, 0, 0, 0);
    #2;
    n_reset = 1'b0;
    #1;
    chk("arst_count", bus.fifo_count, 0);
    chk("arst_valid", bus.rx_valid, 0);
    chk("arst_data", bus.rx_data, 0);
    sb_q.delete();
    bus.spi_cs = 1'b1;
    step();
    n_reset = 1'b1;
    step();
    send_bits(8'h03, 8, 0, 0, 1);
    bus.spi_cs = 1'b1;
    step();
    chk("arst_after_count", bus.fifo_count, 1);
    chk("arst_after_ferr", bus.frame_err, 0);
    pop_chk("arst_after_pop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_mosi_rx.md
Name: spi_mosi_rx

Overview:
Receive-side stage directly downstream of spi_mosi.
- Samples the serial MOSI line bit by bit on spi_clk while spi_cs is low.
- Reassembles bits MSB-first into DATA_WIDTH-bit bytes.
- Buffers complete bytes in a small first-word-fall-through FIFO, which the control logic drains with a read strobe.
- Flags overruns and frames that end in the middle of a byte.

Parameters:
DATA_WIDTH, 8, bits per SPI byte
FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2
ADDR_WIDTH, 2, log2(FIFO_DEPTH)

Ports:
spi_clk  input  1  single clock; all state updates on rising edge
n_reset  input  1  asynchronous, active-low reset
spi_cs  input  1  chip select, active low; frame active while 0
spi_mosi_serial  input  1  serial data from spi_mosi, MSB first
rd_en  input  1  pop head byte; ignored when FIFO empty
ovr_clr  input  1  clears the sticky overrun flag
rx_data  output  DATA_WIDTH  FIFO head byte (first-word-fall-through); valid when rx_valid=1
rx_valid  output  1  FIFO not empty
fifo_full  output  1  FIFO count equals FIFO_DEPTH
fifo_count  output  ADDR_WIDTH+1  number of bytes held
overrun  output  1  sticky; set when a completed byte is dropped because the FIFO is full
frame_err  output  1  one-cycle pulse when spi_cs rises with a partial byte

Behaviour:
- Reset (n_reset=0, asynchronous):
  - All outputs reset: rx_data=0, rx_valid=0, fifo_full=0, fifo_count=0, overrun=0, frame_err=0.
  - Internal state: pointers=0, bit_cnt=0, shift register=0, FSM=IDLE.
  - FIFO memory cleared to 0.
- FSM state IDLE:
  - Entered at reset.
  - Held while spi_cs=1; bit_cnt held at 0.
  - On a rising edge with spi_cs=0: sample spi_mosi_serial as bit 7, set bit_cnt=1, go to SHIFT.
- FSM state SHIFT, each rising edge with spi_cs=0:
  - shift_reg <= {shift_reg[DATA_WIDTH-2:0], spi_mosi_serial}; bit_cnt increments.
  - When the sampled bit is the DATA_WIDTH-th bit: the complete byte {shift_reg[DATA_WIDTH-2:0], spi_mosi_serial} is pushed on that same edge.
  - After that edge bit_cnt=0 and the FSM stays in SHIFT, so back-to-back bytes need no idle gap.
- spi_cs=1 seen in SHIFT:
  - If bit_cnt≠0: discard the partial byte and pulse frame_err=1 for exactly one cycle.
  - bit_cnt<=0, go to IDLE.
  - If bit_cnt==0: return to IDLE silently, no error.
- Latency: rx_valid and rx_data reflect the new byte one cycle after the edge that samples its last bit, when the FIFO was empty.
- FIFO:
  - Push happens on byte completion, pop on rd_en=1 with count>0.
  - Push and pop in the same cycle: both happen and count is unchanged. This holds when full, so no overrun in that case.
  - Push when full with no pop: byte dropped and overrun<=1.
  - Pop when empty: no effect, count stays 0.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_full=(count==FIFO_DEPTH); rx_valid=(count!=0).
  - rx_data=mem[rd_ptr]. When empty it shows the last stale entry; consumers qualify with rx_valid.
- overrun:
  - Cleared by ovr_clr=1.
  - If ovr_clr=1 and a new overrun occur in the same cycle, the set wins.
- Reset mid-byte: everything clears immediately and the partial byte is lost. After release, reception resumes at the next spi_cs=0 sample as bit 7.

Test Plan:
- Reset then hold spi_cs=1 for 10 cycles → all outputs 0, fifo_count=0, no frame_err.
- spi_cs=0 for 8 cycles, MOSI 0,0,0,0,0,0,0,1 → rx_valid=1 one cycle after the 8th edge, rx_data=8'h01, fifo_count=1; rd_en pulse → rx_valid=0.
- Continuous 16 cycles with spi_cs=0 carrying 8'h47 then 8'h61 with no rd_en → fifo_count=2; two pops return 8'h47 then 8'h61.
- Send 5 bytes (8'h01..8'h05) with no reads → fifo_full=1 after the 4th byte; overrun=1 after the 5th; pops return 01,02,03,04; ovr_clr → overrun=0.
- FIFO full with rd_en asserted on the completion edge of byte 8'h23 → overrun stays 0, fifo_count stays 4, 8'h23 read last.
- spi_cs rises after 3 bits, then a full byte 8'h0A → single frame_err pulse, no push for the partial bits, next byte received correctly as 8'h0A.
- n_reset pulsed low after 5 bits → immediate clear, then a following full byte 8'h03 received correctly.
